bcd_minsec_timer: RTL
=====================

# bcd_minsec_timer

Downstream consumer of the modulo-N prescaler's terminal-count pulse. Counts single-cycle `tick` pulses as a BCD minutes:seconds value (00:00 to MIN_MAX:59) under a start/pause/clear control FSM. Presents four BCD digits and a wrap pulse, and optionally drives four seven-segment displays. Sits between the prescaler and the board HEX displays.

## Interface
- `MIN_MAX`, default 59: highest minutes value (BCD-legal, 1..99) before wrap to 00:00.
- `Clock` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high. One clock; reset is asynchronous and active-high.
- `tick` input, 1 bit: one-cycle count pulse from the prescaler TC, synchronous to `Clock`.
- `start_stop` input, 1 bit: one-cycle pulse that toggles run/pause.
- `clr` input, 1 bit: synchronous clear, level-sensitive.
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens` output, 4 bits each: registered BCD digits.
- `running` output, 1 bit: high in RUN.
- `wrap` output, 1 bit: one-cycle pulse on rollover MIN_MAX:59 -> 00:00.
- `HEX0`..`HEX3` output, 7 bits each (present only with `TIMER_SEG7_EN`): active-low segments {g..a}. HEX0 = sec_ones, HEX3 = min_tens.

## Operation
- FSM states:
  - IDLE: stopped at 00:00.
  - RUN: counting.
  - PAUSE: stopped, value held.
- Transitions (non-`clr`):
  - IDLE + `start_stop` -> RUN.
  - RUN + `start_stop` -> PAUSE.
  - PAUSE + `start_stop` -> RUN.
- `clr` high in any state -> IDLE, all digits 0, `wrap` 0. `clr` has priority over `start_stop` and `tick`.
- `tick` is counted only when the current state is RUN. Ticks in IDLE or PAUSE are dropped.
- Increment is a BCD cascade:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - At minutes == MIN_MAX and seconds == 59, the value goes to 00:00, `wrap` pulses, and the state stays RUN.
- Digits never hold a non-BCD value. sec_tens never exceeds 5.
- Reset values: state IDLE, all digits 0, `running` 0, `wrap` 0. HEX outputs show "0" (7'b1000000).

## Timing
- Latency is 1 cycle: a `tick` sampled at edge k in RUN shows in the digits after edge k.
- `wrap` is high in the same cycle the digits first read 00:00, for exactly one cycle.
- `running` is decoded from the state register. It rises the cycle after the accepted `start_stop`.
- Simultaneous `start_stop` and `tick` in RUN: the tick is counted and the state goes to PAUSE.
- Simultaneous `start_stop` and `tick` in IDLE or PAUSE: the tick is dropped and the state goes to RUN.
- Back-to-back ticks (tick high on consecutive cycles) are each counted.
- `rst` asserted mid-count clears immediately, independent of `Clock`. Counting resumes only after `rst` is released and a `start_stop` pulse arrives.
- HEX outputs are combinational from the registered digits, so there is no extra latency.

## Configuration
- `TIMER_SEG7_EN` defined:
  - `HEX0`..`HEX3` ports exist.
  - Four decoder instances are compiled in.
  - Digit values 10..15 are unreachable and decode to all segments off.
- Not defined:
  - HEX ports and decoders are absent.
  - BCD digit, `running` and `wrap` outputs are unchanged.

## Structure
- Shared package `timer_pkg`:
  - FSM state typedef (IDLE/RUN/PAUSE).
  - 4-bit BCD digit typedef.
  - Constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
  - Segment constants for 0..9 and blank.
- Sub-module `seg7_decode`: 4-bit BCD in, 7-bit active-low segments out, purely combinational. It is instantiated four times under `TIMER_SEG7_EN`.
- Top level holds the FSM, the digit cascade and the wrap register.

## Test plan
- Reset then 5 `tick`s with no `start_stop` -> digits stay 00:00, `running`=0.
- `start_stop`, then 61 ticks -> 01:01. With SEG7: HEX0=7'b1111001 ("1"), HEX2=7'b1111001.
- MIN_MAX=2: run 180 ticks -> after the 180th tick the digits read 00:00 and `wrap` is high for exactly one cycle. The next tick gives 00:01.
- In RUN, `start_stop` and `tick` on the same cycle at 00:09 -> 00:10 and PAUSE. 3 further ticks -> still 00:10. `start_stop` then 1 tick -> 00:11.
- At 00:45 in RUN, `clr` and `tick` together -> 00:00, IDLE, `running`=0.
- `rst` pulsed asynchronously between edges at 03:27 -> outputs go to 0 and IDLE before the next edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD minutes:seconds timer and its
// seven-segment decoder.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder; codes 10..15
// blank the display.
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_minsec_timer.sv
// BCD mm:ss timer with start/pause/clear FSM and rollover pulse.
// Define TIMER_SEG7_EN to add the HEX0..HEX3 seven-segment outputs.
module bcd_minsec_timer
    import timer_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic       Clock,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
`ifdef TIMER_SEG7_EN
    ,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
`endif
);

    localparam bcd_t MT_MAX = bcd_t'(MIN_MAX / 10);
    localparam bcd_t MO_MAX = bcd_t'(MIN_MAX % 10);

    state_t state, state_nxt;
    logic   cnt_en;
    logic   at_max;

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    // A tick coinciding with start_stop still counts, since the gate uses the current state
    assign cnt_en = tick && (state == RUN) && !clr;
    assign at_max = (min_tens == MT_MAX) && (min_ones == MO_MAX) &&
                    (sec_tens == SEC_TENS_MAX) && (sec_ones == DIGIT_MAX);

    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            wrap     <= 1'b0;
        end else if (clr) begin
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (cnt_en) begin
                if (at_max) begin
                    sec_ones <= '0;
                    sec_tens <= '0;
                    min_ones <= '0;
                    min_tens <= '0;
                    wrap     <= 1'b1;
                end else if (sec_ones != DIGIT_MAX) begin
                    sec_ones <= sec_ones + 4'd1;
                end else begin
                    sec_ones <= '0;
                    if (sec_tens != SEC_TENS_MAX) begin
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_tens <= '0;
                        if (min_ones != DIGIT_MAX) begin
                            min_ones <= min_ones + 4'd1;
                        end else begin
                            min_ones <= '0;
                            min_tens <= min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef TIMER_SEG7_EN
    seg7_decode u_hex0 (.digit(sec_ones), .seg(HEX0));
    seg7_decode u_hex1 (.digit(sec_tens), .seg(HEX1));
    seg7_decode u_hex2 (.digit(min_ones), .seg(HEX2));
    seg7_decode u_hex3 (.digit(min_tens), .seg(HEX3));
`endif

endmodule
